crossroad_light: RTL and testbench

CROSSROAD_LIGHT -- requirements
Module: crossroad_light

---
 rtl/crossroad_pkg.sv | 50 +++++
 rtl/tick_gen.sv | 29 ++
 rtl/crossroad_light.sv | 146 ++++++++++++++
 tb/tb_crossroad_light.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crossroad_pkg.sv
// Shared lamp and state encodings for the crossroad traffic-light controller.
package crossroad_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    OFF    = 2'd3
  } lamp_e;

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    NIGHT_ON  = 3'd6,
    NIGHT_OFF = 3'd7
  } state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic lamp_e ns_lamp(input state_e s);
    lamp_e l;
    case (s)
      NS_GREEN:  l = GREEN;
      NS_YELLOW: l = YELLOW;
      NIGHT_ON:  l = YELLOW;
      NIGHT_OFF: l = OFF;
      default:   l = RED;
    endcase
    return l;
  endfunction

  function automatic lamp_e ew_lamp(input state_e s);
    lamp_e l;
    case (s)
      EW_GREEN:  l = GREEN;
      EW_YELLOW: l = YELLOW;
      NIGHT_ON:  l = YELLOW;
      NIGHT_OFF: l = OFF;
      default:   l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divides clk down to a registered one-cycle tick every DIV cycles.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic res,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_r;

  // Tick is registered one count early so it lands exactly DIV cycles after reset.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_r <= {CNT_W{1'b0}};
      tick  <= 1'b0;
    end else begin
      tick  <= (cnt_r == CNT_W'(DIV - 2));
      if (cnt_r == CNT_W'(DIV - 1)) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/crossroad_light.sv
// Crossroad traffic-light controller with pedestrian walk phase and night blinking.
module crossroad_light
  import crossroad_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned GREEN_S     = 21,
  parameter int unsigned YELLOW_S    = 3,
  parameter int unsigned ALLRED_S    = 2,
  parameter int unsigned PED_S       = 10,
  parameter int unsigned MIN_GREEN_S = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ped_req,
  input  logic       night,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam int unsigned MAX_D = max2(max2(GREEN_S, YELLOW_S), max2(ALLRED_S, PED_S));
  localparam int unsigned CW    = $clog2(MAX_D) + 1;
  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_S - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_S - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_S - 1);
  localparam logic [CW-1:0] PED_LAST    = CW'(PED_S - 1);
  localparam logic [CW-1:0] MING_LAST   = CW'(MIN_GREEN_S - 1);

  if (TICK_DIV < 2 || GREEN_S < 1 || YELLOW_S < 1 || ALLRED_S < 1 || PED_S < 1 ||
      MIN_GREEN_S < 1 || MIN_GREEN_S > GREEN_S) begin : g_bad_cfg
    $error("crossroad_light: illegal timing parameters");
  end

  logic          tick_s;
  state_e        state_r, state_next_s;
  logic [CW-1:0] sec_cnt_r, sec_next_s, allred_last_s;
  logic          ped_pending_r, pending_next_s;
  logic          walk_r, walk_next_s;
  logic          change_s, enter_walk_s, accept_s;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .res  (res),
    .tick (tick_s)
  );

  // Next-state selection; night is only honoured from the all-red clearances.
  always_comb begin
    state_next_s  = state_r;
    allred_last_s = walk_r ? PED_LAST : ALLRED_LAST;
    case (state_r)
      ALLRED_A, ALLRED_B: begin
        if (tick_s && night) begin
          state_next_s = NIGHT_ON;
        end else if (tick_s && sec_cnt_r == allred_last_s) begin
          state_next_s = (state_r == ALLRED_A) ? NS_GREEN : EW_GREEN;
        end else begin
          state_next_s = state_r;
        end
      end
      NS_GREEN, EW_GREEN: begin
        if (tick_s && (sec_cnt_r == GREEN_LAST ||
                       (ped_pending_r && sec_cnt_r >= MING_LAST))) begin
          state_next_s = (state_r == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
        end else begin
          state_next_s = state_r;
        end
      end
      NS_YELLOW, EW_YELLOW: begin
        if (tick_s && sec_cnt_r == YELLOW_LAST) begin
          state_next_s = (state_r == NS_YELLOW) ? ALLRED_B : ALLRED_A;
        end else begin
          state_next_s = state_r;
        end
      end
      NIGHT_ON: begin
        if (tick_s) begin
          state_next_s = night ? NIGHT_OFF : ALLRED_A;
        end else begin
          state_next_s = state_r;
        end
      end
      NIGHT_OFF: begin
        if (tick_s) begin
          state_next_s = night ? NIGHT_ON : ALLRED_A;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ALLRED_A;
    endcase
  end

  // Second counter, pending request and walk flag; a new press outranks the clear.
  always_comb begin
    change_s       = (state_next_s != state_r);
    enter_walk_s   = change_s && ped_pending_r &&
                     (state_next_s == ALLRED_A || state_next_s == ALLRED_B);
    accept_s       = ped_req && (state_r != NIGHT_ON) && (state_r != NIGHT_OFF);
    sec_next_s     = sec_cnt_r;
    pending_next_s = ped_pending_r;
    walk_next_s    = walk_r;
    if (change_s) begin
      sec_next_s  = {CW{1'b0}};
      walk_next_s = enter_walk_s;
    end else if (tick_s) begin
      sec_next_s  = sec_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      walk_next_s = walk_r;
    end else begin
      sec_next_s  = sec_cnt_r;
      walk_next_s = walk_r;
    end
    if (accept_s) begin
      pending_next_s = 1'b1;
    end else if (enter_walk_s) begin
      pending_next_s = 1'b0;
    end else begin
      pending_next_s = ped_pending_r;
    end
  end

  // State and lamp registers; lamps follow the next state so they align with phase.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r       <= ALLRED_A;
      sec_cnt_r     <= {CW{1'b0}};
      ped_pending_r <= 1'b0;
      walk_r        <= 1'b0;
      ns_light      <= RED;
      ew_light      <= RED;
      ped_walk      <= 1'b0;
      phase         <= 3'd0;
    end else begin
      state_r       <= state_next_s;
      sec_cnt_r     <= sec_next_s;
      ped_pending_r <= pending_next_s;
      walk_r        <= walk_next_s;
      ns_light      <= ns_lamp(state_next_s);
      ew_light      <= ew_lamp(state_next_s);
      ped_walk      <= walk_next_s;
      phase         <= state_next_s;
    end
  end

endmodule

// File: tb/tb_crossroad_light.sv
// Self-checking bench: tick-level reference model plus directed literal checkpoints.
module tb_crossroad_light;

  localparam int TD     = 4;
  localparam int G_S    = 21;
  localparam int Y_S    = 3;
  localparam int AR_S   = 2;
  localparam int P_S    = 10;
  localparam int MING_S = 8;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       ped_req = 1'b0;
  logic       night = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic       ped_walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  crossroad_light #(
    .TICK_DIV(TD), .GREEN_S(G_S), .YELLOW_S(Y_S), .ALLRED_S(AR_S),
    .PED_S(P_S), .MIN_GREEN_S(MING_S)
  ) dut (
    .clk(clk), .res(res), .ped_req(ped_req), .night(night),
    .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk), .phase(phase)
  );

  always #5 clk = ~clk;

  // Model: phase index 0..5 in the cycle order, 6/7 = blink on/off; el = ticks spent.
  typedef struct packed {
    int   ph;
    int   el;
    logic pend;
    logic walk;
    int   cyc;
  } m_t;

  m_t m;

  function automatic int dur_of(input int ph, input logic walk);
    if (ph == 0 || ph == 3) return walk ? P_S : AR_S;
    else if (ph == 1 || ph == 4) return G_S;
    else return Y_S;
  endfunction

  function automatic m_t step(input m_t s, input logic pr, input logic nt);
    m_t   n;
    logic tk, leave, acc;
    int   nxt;
    n     = s;
    leave = 1'b0;
    nxt   = s.ph;
    n.cyc = s.cyc + 1;
    tk    = (n.cyc % TD) == 0;
    acc   = pr && (s.ph < 6);
    if (tk) begin
      n.el = s.el + 1;
      if (s.ph >= 6) begin
        leave = 1'b1;
        nxt   = !nt ? 0 : (s.ph == 6 ? 7 : 6);
      end else if ((s.ph == 0 || s.ph == 3) && nt) begin
        leave = 1'b1;
        nxt   = 6;
      end else if (n.el >= dur_of(s.ph, s.walk) ||
                   ((s.ph == 1 || s.ph == 4) && s.pend && n.el >= MING_S)) begin
        leave = 1'b1;
        nxt   = (s.ph + 1) % 6;
      end
    end
    if (acc) n.pend = 1'b1;
    if (leave) begin
      n.el   = 0;
      n.walk = 1'b0;
      if ((nxt == 0 || nxt == 3) && s.pend) begin
        n.walk = 1'b1;
        if (!acc) n.pend = 1'b0;
      end
    end
    n.ph = nxt;
    return n;
  endfunction

  function automatic int ns_exp(input int ph);
    case (ph)
      1: return 2;
      2: return 1;
      6: return 1;
      7: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int ew_exp(input int ph);
    case (ph)
      4: return 2;
      5: return 1;
      6: return 1;
      7: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge res) begin
    if (res) m <= '0;
    else     m <= step(m, ped_req, night);
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      checks = checks + 4;
      if (int'(ns_light) != ns_exp(m.ph)) begin
        errors++;
        $display("FAIL model_ns cyc=%0d: got %0d expected %0d", m.cyc, ns_light, ns_exp(m.ph));
      end
      if (int'(ew_light) != ew_exp(m.ph)) begin
        errors++;
        $display("FAIL model_ew cyc=%0d: got %0d expected %0d", m.cyc, ew_light, ew_exp(m.ph));
      end
      if (ped_walk !== m.walk) begin
        errors++;
        $display("FAIL model_walk cyc=%0d: got %0d expected %0d", m.cyc, ped_walk, m.walk);
      end
      if (int'(phase) != m.ph) begin
        errors++;
        $display("FAIL model_phase cyc=%0d: got %0d expected %0d", m.cyc, phase, m.ph);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_to(input int k);
    while (m.cyc < k) @(negedge clk);
  endtask

  task automatic wait_phase(input int p, input int budget, input string name);
    int n;
    n = 0;
    while (int'(phase) != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(phase) != p) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: phase %0d expected %0d", name, phase, p);
    end
  endtask

  initial begin
    int t;
    #1 res = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ns", ns_light, 0);
    chk("reset_phase", phase, 0);
    res = 1'b0;

    // Free-running cycle: 52 ticks = 208 clk
    wait_to(7);   chk("arA_end", phase, 0);
    wait_to(8);   chk("nsg_start", phase, 1); chk("nsg_lamp", ns_light, 2);
    wait_to(91);  chk("nsg_last", phase, 1);
    wait_to(92);  chk("nsy_start", phase, 2);
    wait_to(104); chk("arB_start", phase, 3);
    wait_to(112); chk("ewg_start", phase, 4); chk("ewg_lamp", ew_light, 2);
    wait_to(196); chk("ewy_start", phase, 5);
    wait_to(207); chk("ewy_last", phase, 5);
    wait_to(208); chk("cycle_wrap", phase, 0);

    // Pedestrian pulse at green tick 2 -> cut at tick 8, walk 10 ticks
    wait_to(224); ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    wait_to(247); chk("ped2_green", phase, 1);
    wait_to(248); chk("ped2_cut", phase, 2);
    wait_to(260); chk("ped2_walk_on", ped_walk, 1); chk("ped2_arB", phase, 3);
    wait_to(299); chk("ped2_walk_last", ped_walk, 1);
    wait_to(300); chk("ped2_walk_off", ped_walk, 0); chk("ped2_ewg", phase, 4);

    // Pedestrian at green tick 15 -> immediate cut
    wait_to(396); chk("arA_nowalk", ped_walk, 0);
    wait_to(464); ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    wait_to(467); chk("ped15_green", phase, 1);
    wait_to(468); chk("ped15_cut", phase, 2);
    wait_to(480); chk("ped15_walk", ped_walk, 1);

    // Night requested during EW green
    wait_phase(4, 1000, "wait_ewg");
    night = 1'b1;
    wait_phase(6, 1000, "wait_night");
    t = m.cyc;
    chk("night_on0", ns_light, 1);
    wait_to(t + 4); chk("night_off", ns_light, 3); chk("night_off_ew", ew_light, 3);
    wait_to(t + 8); chk("night_on1", ew_light, 1);
    night = 1'b0;
    wait_to(t + 12); chk("night_exit", phase, 0);
    wait_to(t + 19); chk("night_arA_last", phase, 0);
    wait_to(t + 20); chk("night_nsg", phase, 1);

    // Reset mid NS yellow
    wait_phase(2, 1000, "wait_nsy");
    repeat (2) @(negedge clk);
    res = 1'b1;
    #1;
    chk("rst_ns", ns_light, 0); chk("rst_ew", ew_light, 0);
    chk("rst_walk", ped_walk, 0); chk("rst_phase", phase, 0);
    @(negedge clk); res = 1'b0;
    wait_to(7); chk("rst_arA_last", phase, 0);
    wait_to(8); chk("rst_nsg", phase, 1);

    // Request held across walk entry -> walk repeats
    ped_req = 1'b1;
    wait_to(40); chk("hold_cut", phase, 2);
    wait_to(52); chk("hold_walk1", ped_walk, 1);
    wait_to(60); ped_req = 1'b0;
    wait_to(124); chk("hold_cut2", phase, 5);
    wait_to(136); chk("hold_walk2", ped_walk, 1); chk("hold_arA", phase, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ped_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) night = ~night;
    end
    night = 1'b0;
    ped_req = 1'b0;
    repeat (200) @(negedge clk);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
